// File: rtl/mem_pkg.sv
// Shared types and defaults for the multicycle-path memory responder.
// State and op encodings are used by mem_responder and its testbench.
package mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_responder_array.sv
// Single-port synchronous RAM (DEPTH x DATA_W) with registered read data.
// Contents are never cleared; only the read register is reset.
module mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Unified instruction/data memory slave with configurable wait states.
// Optional out-of-range checking (err port) is enabled by MEM_RANGE_CHK_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy
`ifdef MEM_RANGE_CHK_EN
    ,
    output logic              err
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    op_t                 op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                exec;
    logic                oor;
    logic                arr_we, arr_re;
    logic [DATA_W-1:0]   arr_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latches carry no reset: they are only consumed from BUSY.
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        exec    = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (mem_read || mem_write) begin
                    op_d    = mem_write ? OP_WR : OP_RD;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    exec    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_RANGE_CHK_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic err_q;
    logic zero_q;

    assign oor = ({1'b0, addr_q} >= DEPTH_L);

    // zero_q forces rdata to 0 after an out-of-range read until the next good read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (exec) begin
            if (oor) begin
                err_q <= 1'b1;
            end
            if (op_q == OP_RD) begin
                zero_q <= oor;
            end
        end
    end

    assign err   = err_q;
    assign rdata = zero_q ? '0 : arr_rdata;
`else
    assign oor   = 1'b0;
    assign rdata = arr_rdata;
`endif

    // Gating with reset keeps an access aborted at the same edge from committing.
    assign arr_we = exec && reset && (op_q == OP_WR) && !oor;
    assign arr_re = exec && reset && (op_q == OP_RD) && !oor;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst_n (reset),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (addr_q[IDX_W-1:0]),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    assign ready = (state_q == RESP);
    assign busy  = (state_q == BUSY);

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Unified instruction/data memory slave for the multicycle control path.
- Services the read and write strobes issued by the control FSM, using the address selected by the PC-or-ALU address mux (IorD).
- Wait-state timing is configurable, so the control FSM can hold Fetch/Mem states until the responder reports completion.
- Memory array is word-addressed; one word per access.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 8, word address width.
- DEPTH, 256, number of implemented words; must be ≤ 2**ADDR_W.
- WAIT_CYCLES, 2, extra wait states before the access completes; 0 is legal.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- mem_read  input  1  read request strobe (MemRead).
- mem_write  input  1  write request strobe (Memwrite).
- addr  input  ADDR_W  word address (IorD mux output).
- wdata  input  DATA_W  write data.
- rdata  output  DATA_W  read data; valid while ready=1, then held.
- ready  output  1  one-cycle completion pulse for a read or a write.
- busy  output  1  high while a request is accepted but not yet completed.
- err  output  1  out-of-range flag; present only with MEM_RANGE_CHK_EN.

Behaviour:
- Reset (reset=0 at an edge):
  - State goes to IDLE; rdata=0, ready=0, busy=0, err=0, wait counter=0.
  - Array contents are NOT cleared.
  - Reset in BUSY aborts the pending access; a pending write is never committed.
- States: IDLE, BUSY, RESP (encoding in package).
- Acceptance:
  - A request is sampled in IDLE or RESP when mem_read|mem_write=1.
  - On acceptance, addr, wdata and the op are latched, the counter is loaded with WAIT_CYCLES, and the state goes to BUSY.
  - If both strobes are 1, the write wins and no read is performed.
- BUSY:
  - busy=1; the counter decrements each cycle; strobes and input changes are ignored.
  - At the edge where the counter is 0, the access executes: the write commits to the array, or the read loads rdata. The state then goes to RESP.
- RESP:
  - ready=1 for exactly this cycle; busy=0.
  - With no new request, the state returns to IDLE.
  - A request present in RESP is accepted back-to-back, going directly to BUSY.
- Latency: for a request sampled at edge E0, ready is high in the cycle after edge E0+WAIT_CYCLES+1.
  - WAIT_CYCLES=0 → ready in the cycle after E0+1.
- rdata:
  - Updated only on read completion; held through IDLE and through writes.
  - A write-then-read to the same address returns the new data.
- Address width: the address is used modulo DEPTH only when range checking is disabled (low bits index the array).

Optional Feature:
- Macro: MEM_RANGE_CHK_EN.
- Defined:
  - Latched address ≥ DEPTH → the access is still timed normally and ready pulses.
  - A write is dropped; a read returns rdata=0.
  - err=1 in the same cycle as ready.
  - err is sticky until reset.
- Undefined:
  - No err port.
  - The address wraps via the low bits (addr % DEPTH when DEPTH is a power of two).

Decomposition:
- Package mem_pkg contains:
  - state encoding constants IDLE/BUSY/RESP (2-bit);
  - default DATA_W/ADDR_W widths;
  - op encoding (OP_RD, OP_WR).
- Sub-module mem_array:
  - single-port synchronous RAM (DEPTH×DATA_W), with we, addr, wdata, rdata;
  - read data registered;
  - instantiated once.
- The FSM, counter and latches stay in mem_responder.

Test Plan:
- Reset behaviour: hold reset=0 for 2 cycles with mem_read=1 → rdata=0, ready=0, busy=0 throughout; release → the request is accepted on the next edge.
- Write then read, WAIT_CYCLES=2:
  - write addr=0x10, wdata=0xBEEF → busy for 3 cycles, then ready pulses once;
  - read 0x10 → ready with rdata=0xBEEF exactly 4 cycles after the request edge.
- Back-to-back requests with WAIT_CYCLES=0: reads of 0x01, 0x02 and 0x03 held continuously → ready every 2nd cycle; rdata sequence matches preloaded values; no request lost.
- Simultaneous strobes: mem_read=mem_write=1, addr=0x20, wdata=0x1234 → write commits and rdata keeps its prior value; a later read of 0x20 returns 0x1234.
- Reset mid-access: write 0x30=0xAAAA, assert reset while busy=1 → no ready pulse; a read of 0x30 afterwards returns its old value.
- MEM_RANGE_CHK_EN, DEPTH=128:
  - read addr=0xC0 → ready with rdata=0 and err=1;
  - write to 0x90 is dropped; err stays 1 until reset.
